// File: rtl/pe_dot_sequencer.sv
// Dot-product job sequencer for a single PE instance.
// It clears the PE accumulator and loads the B vector into the PE RAM. It then
// issues the A elements one at a time. The accumulation feedback path in the PE
// allows only one operation in flight, so each issue waits for the PE result
// before the next A element is fetched.
module pe_dot_sequencer #(
    parameter int L_RAM_SIZE = 6,
    parameter int RD_LAT     = 2,
    parameter int CLR_CYC    = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [L_RAM_SIZE:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           result,
    input  logic [31:0]           b_tdata,
    input  logic                  b_tvalid,
    output logic                  b_tready,
    input  logic [31:0]           a_tdata,
    input  logic                  a_tvalid,
    output logic                  a_tready,
    output logic                  pe_aresetn,
    output logic [31:0]           pe_ain,
    output logic [31:0]           pe_din,
    output logic [L_RAM_SIZE-1:0] pe_addr,
    output logic                  pe_we,
    output logic                  pe_valid,
    input  logic                  pe_dvalid,
    input  logic [31:0]           pe_dout
);

    // One shared cycle counter serves CLEAR, SETTLE and WAIT.
    localparam int CNT_W = 16;
    // The largest legal length is 2**L_RAM_SIZE. The index is one bit wider, so
    // that count terminates without wrapping.
    localparam logic [L_RAM_SIZE:0] MAX_LEN = {1'b1, {L_RAM_SIZE{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD_B,
        S_FETCH_A,
        S_SETTLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [L_RAM_SIZE:0]     idx_q, idx_d;
    logic [L_RAM_SIZE:0]     len_q, len_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [31:0]             result_q, result_d;
    logic [31:0]             pe_ain_q, pe_ain_d;
    logic [31:0]             pe_din_q, pe_din_d;
    logic [L_RAM_SIZE-1:0]   pe_addr_q, pe_addr_d;
    logic                    pe_we_q, pe_we_d;
    logic                    pe_valid_q, pe_valid_d;

    logic [L_RAM_SIZE:0]     idx_inc;
    logic [CNT_W-1:0]        cnt_inc;

    assign idx_inc = idx_q + (L_RAM_SIZE+1)'(1);
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Handshake readies and the PE reset decode straight from the state.
    assign b_tready   = (state_q == S_LOAD_B);
    assign a_tready   = (state_q == S_FETCH_A);
    assign pe_aresetn = aresetn & (state_q != S_CLEAR);

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign result   = result_q;
    assign pe_ain   = pe_ain_q;
    assign pe_din   = pe_din_q;
    assign pe_addr  = pe_addr_q;
    assign pe_we    = pe_we_q;
    assign pe_valid = pe_valid_q;

    // Next-state logic: job sequencing and all registered outputs.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        result_d   = result_q;
        pe_ain_d   = pe_ain_q;
        pe_din_d   = pe_din_q;
        pe_addr_d  = pe_addr_q;
        pe_we_d    = 1'b0;
        pe_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len;
                    error_d = 1'b0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    if ((len == '0) || (len > MAX_LEN)) begin
                        // Reject the job at once. The previous result is kept.
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                if (cnt_q == CNT_W'(CLR_CYC - 1)) begin
                    idx_d   = '0;
                    state_d = S_LOAD_B;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_LOAD_B: begin
                if (b_tvalid) begin
                    pe_we_d   = 1'b1;
                    pe_addr_d = idx_q[L_RAM_SIZE-1:0];
                    pe_din_d  = b_tdata;
                    if (idx_inc == len_q) begin
                        idx_d   = '0;
                        state_d = S_FETCH_A;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end
            S_FETCH_A: begin
                if (a_tvalid) begin
                    // pe_ain and pe_addr now hold until the PE answers.
                    pe_ain_d  = a_tdata;
                    pe_addr_d = idx_q[L_RAM_SIZE-1:0];
                    cnt_d     = '0;
                    state_d   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // Give the PE RAM read and the conversion register time to settle.
                if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                    pe_valid_d = 1'b1;
                    state_d    = S_ISSUE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (pe_dvalid) begin
                    result_d = pe_dout;
                    idx_d    = idx_inc;
                    if (idx_inc == len_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH_A;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers. A low aresetn aborts any job in progress.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            result_q   <= '0;
            pe_ain_q   <= '0;
            pe_din_q   <= '0;
            pe_addr_q  <= '0;
            pe_we_q    <= 1'b0;
            pe_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            result_q   <= result_d;
            pe_ain_q   <= pe_ain_d;
            pe_din_q   <= pe_din_d;
            pe_addr_q  <= pe_addr_d;
            pe_we_q    <= pe_we_d;
            pe_valid_q <= pe_valid_d;
        end
    end

endmodule

// File: doc/pe_dot_sequencer.md
Name: pe_dot_sequencer

Overview:
- Sequences one my_pe instance through a complete dot-product job.
- Clears the PE accumulator, streams the B vector into the PE local RAM, then issues A elements one at a time. Each issue waits for the PE result, because the accumulation feedback path allows only one operation in flight.
- Sits between the AXI-stream/register front end and the PE. Reports the final FP32 sum, a done pulse and an error flag.

Parameters:
- L_RAM_SIZE, 6, PE RAM address width; maximum vector length is 2**L_RAM_SIZE.
- RD_LAT, 2, cycles from pe_addr/pe_ain becoming stable to pe_valid assertion (RAM read plus conversion register).
- CLR_CYC, 2, cycles pe_aresetn is held low to clear the PE accumulator and FP core.
- TIMEOUT, 64, maximum cycles spent in WAIT before error.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- start  in  1  job start, sampled in IDLE only
- len  in  L_RAM_SIZE+1  vector length, latched on start
- busy  out  1  high from start acceptance through DONE
- done  out  1  one-cycle pulse at job end
- error  out  1  sticky until next start: bad len or timeout
- result  out  32  FP32 accumulated sum, valid when done pulses
- b_tdata  in  32  B element (fp16 in PE byte order)
- b_tvalid  in  1  B element valid
- b_tready  out  1  B element ready
- a_tdata  in  32  A element (fp16 in PE byte order)
- a_tvalid  in  1  A element valid
- a_tready  out  1  A element ready
- pe_aresetn  out  1  PE reset = aresetn AND NOT clear
- pe_ain  out  32  PE port A
- pe_din  out  32  PE RAM write data
- pe_addr  out  L_RAM_SIZE  PE RAM address
- pe_we  out  1  PE RAM write enable
- pe_valid  out  1  PE operation valid
- pe_dvalid  in  1  PE result valid
- pe_dout  in  32  PE result

Behaviour:
- Reset values:
  - busy, done, error, b_tready, a_tready, pe_we, pe_valid = 0.
  - result, pe_ain, pe_din, pe_addr = 0.
  - pe_aresetn = 0 while aresetn = 0.
  - State = IDLE.
- Reset mid-job aborts the job; no done is produced.
- All outputs are registered except pe_aresetn, b_tready and a_tready, which decode from state.
- IDLE:
  - start=1 latches len, clears error and the element index idx, and sets busy.
  - len==0 or len>2**L_RAM_SIZE: set error, go to DONE with result unchanged.
  - Otherwise go to CLEAR.
  - start while busy is ignored.
- CLEAR: pe_aresetn=0 for CLR_CYC cycles, then go to LOAD_B with idx=0.
- LOAD_B:
  - b_tready=1.
  - On each handshake: next cycle pe_we=1, pe_addr=idx, pe_din=b_tdata; idx increments.
  - After len handshakes: idx=0, go to FETCH_A. b_tready drops in the cycle after the last handshake.
- FETCH_A:
  - a_tready=1, pe_we=0.
  - On handshake: pe_ain=a_tdata, pe_addr=idx, go to SETTLE.
- SETTLE: wait RD_LAT cycles, then go to ISSUE.
- ISSUE: pe_valid=1 for exactly one cycle, then go to WAIT.
- pe_ain and pe_addr hold constant from the FETCH_A handshake until WAIT exits.
- WAIT:
  - On pe_dvalid: result=pe_dout and idx++. If idx==len go to DONE, else go to FETCH_A.
  - If TIMEOUT cycles pass without pe_dvalid: set error, go to DONE.
  - pe_dvalid outside WAIT is ignored.
- DONE: done=1 for one cycle, busy=0 in the following cycle, go to IDLE.
- Latency:
  - A back-to-back A stream gives RD_LAT + 2 + PE latency cycles per element.
  - A stalled stream (valid low) simply holds the FSM in LOAD_B or FETCH_A; there is no timeout there.
- Index counter is L_RAM_SIZE+1 bits, so len=2**L_RAM_SIZE terminates correctly without wrap-around.

Test Plan:
- len=4, B=0x00400000 x4 (fp16 2.0), A=0x003C0000 x4 (fp16 1.0), behavioural PE with 8-cycle latency -> done once, result=0x41000000 (8.0), error=0, exactly 4 pe_valid pulses and 4 pe_we pulses, pe_aresetn low 2 cycles.
- len=0 -> done within 3 cycles of start, error=1, no pe_we/pe_valid, result unchanged.
- len=64 with b_tvalid/a_tvalid toggled randomly -> pe_addr covers 0..63 in order, no skipped or duplicate writes, done once.
- PE model never returns dvalid -> error=1 and done exactly TIMEOUT+1 cycles after pe_valid; a following good job clears error.
- aresetn=0 for 1 cycle mid-WAIT -> all outputs at reset values, no done; a new start runs a clean job with the correct result.
- start pulsed during busy, plus spurious pe_dvalid in FETCH_A -> both ignored, result identical to the first scenario.
